// File: rtl/decode_stage.sv
// MIPS decode stage: decodes one instruction word into an ALU/control bundle,
// held in a single output register with valid/ready handshaking on both sides.
// A one-cycle bubble is inserted when the incoming instruction reads the
// destination of a load currently held in the output register.
module decode_stage #(
  parameter logic [5:0] ILLEGAL_FUNC = 6'b010000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] Instr_in,
  input  logic        Valid_in,
  output logic        Ready_out,
  input  logic        Ready_in,
  input  logic        Flush_in,
  output logic        Valid_out,
  output logic [5:0]  Func_out,
  output logic [31:0] Imm_out,
  output logic        ASel_out,
  output logic        BSel_out,
  output logic [4:0]  Rs_out,
  output logic [4:0]  Rt_out,
  output logic [4:0]  Wreg_out,
  output logic        RegWrite_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        Link_out,
  output logic        Illegal_out
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnAdd     = 6'b100000;
  localparam logic [5:0] FnJumpReg = 6'b111011;
  localparam logic [5:0] FnJump    = 6'b111010;

  // Instruction fields
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_zext;

  assign op       = Instr_in[31:26];
  assign rs       = Instr_in[25:21];
  assign rt       = Instr_in[20:16];
  assign rd       = Instr_in[15:11];
  assign funct    = Instr_in[5:0];
  assign imm_sext = {{16{Instr_in[15]}}, Instr_in[15:0]};
  assign imm_zext = {16'h0000, Instr_in[15:0]};

  // Decoded bundle for the current input word
  logic [5:0]  dec_func;
  logic [31:0] dec_imm;
  logic        dec_asel, dec_bsel;
  logic [4:0]  dec_wreg;
  logic        dec_regwrite, dec_memread, dec_memwrite, dec_link, dec_illegal;

  // Output register
  logic        valid_q;
  logic [5:0]  func_q;
  logic [31:0] imm_q;
  logic        asel_q, bsel_q;
  logic [4:0]  rs_q, rt_q, wreg_q;
  logic        regwrite_q, memread_q, memwrite_q, link_q, illegal_q;

  logic uses_rs, uses_rt, hazard, transfer;

  // Decode the incoming instruction into ALU function, immediate and control flags
  always_comb begin
    dec_func     = ILLEGAL_FUNC;
    dec_imm      = 32'h0;
    dec_asel     = 1'b0;
    dec_bsel     = 1'b0;
    dec_wreg     = 5'd0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_link     = 1'b0;
    dec_illegal  = 1'b0;
    case (op)
      OpSpecial: begin
        case (funct)
          6'h00, 6'h02, 6'h03: begin
            dec_func     = funct;
            dec_asel     = 1'b1;
            dec_wreg     = rd;
            dec_regwrite = 1'b1;
          end
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            dec_func     = funct;
            dec_wreg     = rd;
            dec_regwrite = 1'b1;
          end
          6'h08: dec_func = FnJumpReg;
          6'h09: begin
            dec_func     = FnJumpReg;
            dec_link     = 1'b1;
            dec_wreg     = rd;
            dec_regwrite = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OpRegimm: begin
        if (rt == 5'd0 || rt == 5'd1) begin
          dec_func = {5'b11100, rt[0]};
          dec_imm  = imm_sext;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpJ, OpJal: begin
        dec_func = FnJump;
        dec_imm  = {6'b0, Instr_in[25:0]};
        if (op == OpJal) begin
          dec_link     = 1'b1;
          dec_wreg     = 5'd31;
          dec_regwrite = 1'b1;
        end
      end
      OpBeq, OpBne, OpBlez, OpBgtz: begin
        dec_func = {4'b1111, op[1:0]};
        dec_imm  = imm_sext;
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
        dec_bsel     = 1'b1;
        dec_wreg     = rt;
        dec_regwrite = 1'b1;
        case (op)
          OpSlti:  dec_func = 6'b101010;
          OpSltiu: dec_func = 6'b101011;
          OpAndi:  dec_func = 6'b100100;
          OpOri:   dec_func = 6'b100101;
          OpXori:  dec_func = 6'b100110;
          OpLui:   dec_func = ILLEGAL_FUNC;
          default: dec_func = FnAdd;
        endcase
        if (op == OpLui) begin
          dec_imm = {Instr_in[15:0], 16'h0000};
        end else if (op == OpAndi || op == OpOri || op == OpXori) begin
          dec_imm = imm_zext;
        end else begin
          dec_imm = imm_sext;
        end
      end
      OpLw: begin
        dec_func     = FnAdd;
        dec_imm      = imm_sext;
        dec_bsel     = 1'b1;
        dec_wreg     = rt;
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
      end
      OpSw: begin
        dec_func     = FnAdd;
        dec_imm      = imm_sext;
        dec_bsel     = 1'b1;
        dec_memwrite = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Writes to $0 are architecturally discarded
    if (dec_wreg == 5'd0) dec_regwrite = 1'b0;
  end

  // Load-use hazard against the load held in the output register
  always_comb begin
    uses_rs = !(op == OpJ || op == OpJal);
    uses_rt = (op == OpSpecial) || (op == OpSw) || (op == OpBeq) || (op == OpBne);
    hazard  = Valid_in && valid_q && memread_q && (rt_q != 5'd0) &&
              ((uses_rs && rs == rt_q) || (uses_rt && rt == rt_q));
  end

  assign Ready_out = reset_n && (!valid_q || Ready_in) && !hazard && !Flush_in;
  assign transfer  = Valid_in && Ready_out;

  // Output register: load on transfer, drain when consumed, hold otherwise
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      func_q     <= 6'd0;
      imm_q      <= 32'h0;
      asel_q     <= 1'b0;
      bsel_q     <= 1'b0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      wreg_q     <= 5'd0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      link_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (Flush_in) begin
      valid_q <= 1'b0;
    end else if (transfer) begin
      valid_q    <= 1'b1;
      func_q     <= dec_func;
      imm_q      <= dec_imm;
      asel_q     <= dec_asel;
      bsel_q     <= dec_bsel;
      rs_q       <= rs;
      rt_q       <= rt;
      wreg_q     <= dec_wreg;
      regwrite_q <= dec_regwrite;
      memread_q  <= dec_memread;
      memwrite_q <= dec_memwrite;
      link_q     <= dec_link;
      illegal_q  <= dec_illegal;
    end else if (Ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign Valid_out    = valid_q;
  assign Func_out     = func_q;
  assign Imm_out      = imm_q;
  assign ASel_out     = asel_q;
  assign BSel_out     = bsel_q;
  assign Rs_out       = rs_q;
  assign Rt_out       = rt_q;
  assign Wreg_out     = wreg_q;
  assign RegWrite_out = regwrite_q;
  assign MemRead_out  = memread_q;
  assign MemWrite_out = memwrite_q;
  assign Link_out     = link_q;
  assign Illegal_out  = illegal_q;

endmodule
